// File: rtl/leglite_mc_control.sv
// Multicycle LEGLite control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with a mem_ready handshake.
// Define LEGLITE_MC_TRAP_EN to trap undefined opcodes into HALT; otherwise they run as 3-cycle NOPs.
module leglite_mc_control #(
    parameter int OPCODE_W  = 3,
    parameter int ALU_SEL_W = 3,
    parameter int ALU_ADD   = 0,
    parameter int ALU_PASSB = 2,
    parameter int ALU_AND   = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 ifetch,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_src,
    output logic                 reg2loc,
    output logic                 alusrc,
    output logic                 memread,
    output logic                 memwrite,
    output logic                 memtoreg,
    output logic                 regwrite,
    output logic [ALU_SEL_W-1:0] alu_select,
    output logic                 instr_done,
    output logic                 illegal
);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_LD   = 3'd3;
    localparam logic [2:0] OP_ST   = 3'd4;
    localparam logic [2:0] OP_CBZ  = 3'd5;
    localparam logic [2:0] OP_ADDI = 3'd6;
    localparam logic [2:0] OP_ANDI = 3'd7;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
`ifdef LEGLITE_MC_TRAP_EN
        HALT   = 3'd5,
`endif
        WB     = 3'd4
    } state_t;

    typedef struct packed {
        logic                 ifetch;
        logic                 ir_write;
        logic                 pc_write;
        logic                 pc_src;
        logic                 reg2loc;
        logic                 alusrc;
        logic                 memread;
        logic                 memwrite;
        logic                 memtoreg;
        logic                 regwrite;
        logic [ALU_SEL_W-1:0] alu_select;
        logic                 instr_done;
        logic                 illegal;
    } ctrl_t;

    state_t              state_q, state_d;
    logic [OPCODE_W-1:0] op_q;
    ctrl_t               ctrl_c, ctrl;

    function automatic logic op_defined(input logic [OPCODE_W-1:0] op);
        logic [2:0] lo;
        lo = op[2:0];
        return !(|(op >> 3)) && (lo != 3'd1) && (lo != 3'd2);
    endfunction

    logic [2:0] op_lo;
    logic       op_ok;
    assign op_lo = op_q[2:0];
    assign op_ok = op_defined(op_q);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE)
                op_q <= opcode;
        end
    end

    always_comb begin
        state_d = state_q;
        ctrl_c  = '0;
        case (state_q)
            FETCH: begin
                ctrl_c.ifetch = 1'b1;
                if (mem_ready) begin
                    ctrl_c.ir_write = 1'b1;
                    ctrl_c.pc_write = 1'b1;
                    state_d         = DECODE;
                end
            end
            DECODE: begin
                // op_q is not loaded until the end of this cycle, so decode from the live IR field
                ctrl_c.reg2loc = op_defined(opcode) &&
                                 (opcode[2:0] == OP_ST || opcode[2:0] == OP_CBZ);
`ifdef LEGLITE_MC_TRAP_EN
                state_d = op_defined(opcode) ? EXEC : HALT;
`else
                state_d = EXEC;
`endif
            end
            EXEC: begin
                state_d = FETCH;
                if (!op_ok) begin
                    ctrl_c.instr_done = 1'b1;
                end else begin
                    ctrl_c.reg2loc    = (op_lo == OP_ST) || (op_lo == OP_CBZ);
                    ctrl_c.alusrc     = (op_lo == OP_LD) || (op_lo == OP_ST) ||
                                        (op_lo == OP_ADDI) || (op_lo == OP_ANDI);
                    ctrl_c.alu_select = (op_lo == OP_ANDI) ? ALU_SEL_W'(ALU_AND) :
                                        (op_lo == OP_CBZ)  ? ALU_SEL_W'(ALU_PASSB) :
                                                             ALU_SEL_W'(ALU_ADD);
                    case (op_lo)
                        OP_LD, OP_ST: state_d = MEM;
                        OP_CBZ: begin
                            ctrl_c.pc_src     = 1'b1;
                            ctrl_c.pc_write   = zero;
                            ctrl_c.instr_done = 1'b1;
                        end
                        default: state_d = WB;
                    endcase
                end
            end
            MEM: begin
                ctrl_c.reg2loc    = (op_lo == OP_ST);
                ctrl_c.alusrc     = 1'b1;
                ctrl_c.alu_select = ALU_SEL_W'(ALU_ADD);
                ctrl_c.memread    = (op_lo == OP_LD);
                ctrl_c.memwrite   = (op_lo == OP_ST);
                if (mem_ready) begin
                    if (op_lo == OP_LD) begin
                        state_d = WB;
                    end else begin
                        state_d           = FETCH;
                        ctrl_c.instr_done = 1'b1;
                    end
                end
            end
            WB: begin
                ctrl_c.regwrite   = 1'b1;
                ctrl_c.instr_done = 1'b1;
                ctrl_c.memtoreg   = (op_lo == OP_LD);
                state_d           = FETCH;
            end
`ifdef LEGLITE_MC_TRAP_EN
            HALT: begin
                ctrl_c.illegal = 1'b1;
            end
`endif
            default: state_d = FETCH;
        endcase
    end

    // Reset low masks every strobe, so an aborted instruction cannot write anything
    assign ctrl = reset ? ctrl_c : '0;

    assign ifetch     = ctrl.ifetch;
    assign ir_write   = ctrl.ir_write;
    assign pc_write   = ctrl.pc_write;
    assign pc_src     = ctrl.pc_src;
    assign reg2loc    = ctrl.reg2loc;
    assign alusrc     = ctrl.alusrc;
    assign memread    = ctrl.memread;
    assign memwrite   = ctrl.memwrite;
    assign memtoreg   = ctrl.memtoreg;
    assign regwrite   = ctrl.regwrite;
    assign alu_select = ctrl.alu_select;
    assign instr_done = ctrl.instr_done;
    assign illegal    = ctrl.illegal;

endmodule
